// File: rtl/sprite_loader_pkg.sv
// Shared types and constants for the sprite RAM loader.
package sprite_loader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StAddrHi,
        StAddrLo,
        StCntHi,
        StCntLo,
        StData,
        StCheck
    } state_e;

    localparam logic [7:0] SYNC_BYTE   = 8'hA5;
    localparam logic [7:0] CMD_IMAGE   = 8'h01;
    localparam logic [7:0] CMD_PALETTE = 8'h02;

endpackage

// File: rtl/sprite_ram_loader.sv
// Framed byte-stream parser that writes the sprite image RAM and the palette RAM.
// Optional trailing XOR checksum byte enabled by defining SPRITE_LOADER_CHECKSUM_EN.
module sprite_ram_loader
    import sprite_loader_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned HEIGHT    = 48,
    parameter int unsigned PAL_DEPTH = 256,
    localparam int unsigned IMG_DEPTH = WIDTH * HEIGHT,
    localparam int unsigned IMG_AW    = $clog2(IMG_DEPTH)
) (
    input  logic              pixel_clk_in,
    input  logic              rst_in,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid_in,
    output logic              byte_ready_out,
    output logic [IMG_AW-1:0] img_addr_out,
    output logic [7:0]        img_data_out,
    output logic              img_we_out,
    output logic [7:0]        pal_addr_out,
    output logic [23:0]       pal_data_out,
    output logic              pal_we_out,
    output logic              busy_out,
    output logic              load_done_out,
    output logic              load_error_out
);

`ifdef SPRITE_LOADER_CHECKSUM_EN
    localparam state_e FrameEnd = StCheck;
`else
    localparam state_e FrameEnd = StIdle;
`endif

    state_e            state_q, state_d;
    logic              is_pal_q, is_pal_d;
    logic [15:0]       addr_q, addr_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [1:0]        idx_q, idx_d;
    logic [15:0]       rg_q, rg_d;
    logic [IMG_AW-1:0] img_addr_q, img_addr_d;
    logic [7:0]        img_data_q, img_data_d;
    logic              img_we_q, img_we_d;
    logic [7:0]        pal_addr_q, pal_addr_d;
    logic [23:0]       pal_data_q, pal_data_d;
    logic              pal_we_q, pal_we_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic        xfer;
    logic        cmd_ok;
    logic [15:0] cnt_full;
    logic [16:0] frame_end;
    logic [16:0] depth;
    logic        over_depth;
    logic        entry_done;
    logic        last_entry;

    assign byte_ready_out = ~rst_in;
    assign xfer           = byte_valid_in & ~rst_in;
    assign cmd_ok         = (byte_in == CMD_IMAGE) || (byte_in == CMD_PALETTE);
    assign cnt_full       = {cnt_q[15:8], byte_in};
    // 17-bit sum so start + count cannot wrap past the depth check
    assign frame_end      = {1'b0, addr_q} + {1'b0, cnt_full};
    assign depth          = is_pal_q ? 17'(PAL_DEPTH) : 17'(IMG_DEPTH);
    assign over_depth     = frame_end > depth;
    // Image entries are one byte; palette entries complete on the B byte
    assign entry_done     = !is_pal_q || (idx_q == 2'd2);
    assign last_entry     = entry_done && (cnt_q == 16'd1);

`ifdef SPRITE_LOADER_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;
    logic       csum_ok;

    assign csum_ok = (csum_q == byte_in);

    // Running XOR over CMD, header and payload bytes
    always_comb begin
        csum_d = csum_q;
        if (xfer) begin
            case (state_q)
                StCmd:                                          csum_d = byte_in;
                StAddrHi, StAddrLo, StCntHi, StCntLo, StData:   csum_d = csum_q ^ byte_in;
                default: ;
            endcase
        end
    end

    // Checksum accumulator register
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) csum_q <= 8'h00;
        else        csum_q <= csum_d;
    end
`endif

    // State and datapath registers
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            state_q    <= StIdle;
            is_pal_q   <= 1'b0;
            addr_q     <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            rg_q       <= '0;
            img_addr_q <= '0;
            img_data_q <= '0;
            img_we_q   <= 1'b0;
            pal_addr_q <= '0;
            pal_data_q <= '0;
            pal_we_q   <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_pal_q   <= is_pal_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            rg_q       <= rg_d;
            img_addr_q <= img_addr_d;
            img_data_q <= img_data_d;
            img_we_q   <= img_we_d;
            pal_addr_q <= pal_addr_d;
            pal_data_q <= pal_data_d;
            pal_we_q   <= pal_we_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Next-state: one advance per accepted byte
    always_comb begin
        state_d = state_q;
        if (xfer) begin
            unique case (state_q)
                StIdle:   if (byte_in == SYNC_BYTE) state_d = StCmd;
                StCmd:    state_d = cmd_ok ? StAddrHi : StIdle;
                StAddrHi: state_d = StAddrLo;
                StAddrLo: state_d = StCntHi;
                StCntHi:  state_d = StCntLo;
                StCntLo: begin
                    if (over_depth)              state_d = StIdle;
                    else if (cnt_full == 16'd0)  state_d = FrameEnd;
                    else                         state_d = StData;
                end
                StData:   if (last_entry) state_d = FrameEnd;
                StCheck:  state_d = StIdle;
                default:  state_d = StIdle;
            endcase
        end
    end

    // Datapath and registered strobes/pulses
    always_comb begin
        is_pal_d   = is_pal_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        rg_d       = rg_q;
        img_addr_d = img_addr_q;
        img_data_d = img_data_q;
        img_we_d   = 1'b0;
        pal_addr_d = pal_addr_q;
        pal_data_d = pal_data_q;
        pal_we_d   = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        if (xfer) begin
            case (state_q)
                StCmd: begin
                    is_pal_d = (byte_in == CMD_PALETTE);
                    err_d    = !cmd_ok;
                end
                StAddrHi: addr_d[15:8] = byte_in;
                StAddrLo: addr_d[7:0]  = byte_in;
                StCntHi:  cnt_d[15:8]  = byte_in;
                StCntLo: begin
                    cnt_d = cnt_full;
                    idx_d = 2'd0;
                    err_d = over_depth;
`ifndef SPRITE_LOADER_CHECKSUM_EN
                    done_d = !over_depth && (cnt_full == 16'd0);
`endif
                end
                StData: begin
                    if (!is_pal_q) begin
                        img_we_d   = 1'b1;
                        img_addr_d = addr_q[IMG_AW-1:0];
                        img_data_d = byte_in;
                    end else begin
                        case (idx_q)
                            2'd0:    rg_d[15:8] = byte_in;
                            2'd1:    rg_d[7:0]  = byte_in;
                            default: begin
                                pal_we_d   = 1'b1;
                                pal_addr_d = addr_q[7:0];
                                pal_data_d = {rg_q, byte_in};
                            end
                        endcase
                    end
                    if (entry_done) begin
                        addr_d = addr_q + 16'd1;
                        cnt_d  = cnt_q - 16'd1;
                        idx_d  = 2'd0;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
`ifndef SPRITE_LOADER_CHECKSUM_EN
                    done_d = last_entry;
`endif
                end
                StCheck: begin
`ifdef SPRITE_LOADER_CHECKSUM_EN
                    done_d = csum_ok;
                    err_d  = !csum_ok;
`endif
                end
                default: ;
            endcase
        end
    end

    assign img_addr_out   = img_addr_q;
    assign img_data_out   = img_data_q;
    assign img_we_out     = img_we_q;
    assign pal_addr_out   = pal_addr_q;
    assign pal_data_out   = pal_data_q;
    assign pal_we_out     = pal_we_q;
    assign busy_out       = (state_q != StIdle);
    assign load_done_out  = done_q;
    assign load_error_out = err_q;

endmodule

// File: tb/tb_sprite_ram_loader.sv
// Scoreboard bench for sprite_ram_loader: stimulus pushes expected writes and
// done/error events, a negedge monitor pops and compares whenever a strobe fires.
module tb_sprite_ram_loader;

    logic        clk = 1'b0;
    logic        rst_in;
    logic [7:0]  byte_in;
    logic        byte_valid_in;
    logic        byte_ready_out;
    logic [9:0]  img_addr_out;
    logic [7:0]  img_data_out;
    logic        img_we_out;
    logic [7:0]  pal_addr_out;
    logic [23:0] pal_data_out;
    logic        pal_we_out;
    logic        busy_out;
    logic        load_done_out;
    logic        load_error_out;

    always #5 clk = ~clk;

    sprite_ram_loader dut (
        .pixel_clk_in   (clk),
        .rst_in         (rst_in),
        .byte_in        (byte_in),
        .byte_valid_in  (byte_valid_in),
        .byte_ready_out (byte_ready_out),
        .img_addr_out   (img_addr_out),
        .img_data_out   (img_data_out),
        .img_we_out     (img_we_out),
        .pal_addr_out   (pal_addr_out),
        .pal_data_out   (pal_data_out),
        .pal_we_out     (pal_we_out),
        .busy_out       (busy_out),
        .load_done_out  (load_done_out),
        .load_error_out (load_error_out)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [9:0]  exp_img_addr[$];
    logic [7:0]  exp_img_data[$];
    logic [7:0]  exp_pal_addr[$];
    logic [23:0] exp_pal_data[$];
    bit          exp_evt[$];     // 0 = done, 1 = error
    logic [7:0]  frame_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got strobe expected none", name);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        byte_in       = b;
        byte_valid_in = 1'b1;
        @(posedge clk);
        #1;
        byte_valid_in = 1'b0;
        byte_in       = 8'h00;
    endtask

    // Send frame_q verbatim with optional idle gap after each byte
    task automatic send_raw(input int gap);
        foreach (frame_q[i]) begin
            send(frame_q[i]);
            if (gap > 0) idle(gap);
        end
        frame_q.delete();
    endtask

    // Send frame_q plus trailing checksum when the feature is built in
    task automatic send_frame(input int gap);
`ifdef SPRITE_LOADER_CHECKSUM_EN
        begin : csum_blk
            logic [7:0] cs;
            cs = 8'h00;
            for (int i = 1; i < frame_q.size(); i++) cs ^= frame_q[i];
            frame_q.push_back(cs);
        end
`endif
        send_raw(gap);
    endtask

    task automatic exp_img(input logic [9:0] a, input logic [7:0] d);
        exp_img_addr.push_back(a);
        exp_img_data.push_back(d);
    endtask

    task automatic exp_pal(input logic [7:0] a, input logic [23:0] d);
        exp_pal_addr.push_back(a);
        exp_pal_data.push_back(d);
    endtask

    // Monitor: compare every strobe/pulse against the scoreboard
    always @(negedge clk) begin
        if (!rst_in) begin
            if (img_we_out) begin
                if (exp_img_addr.size() == 0) unexpected("img_we");
                else begin
                    check("img_addr", 32'(img_addr_out), 32'(exp_img_addr.pop_front()));
                    check("img_data", 32'(img_data_out), 32'(exp_img_data.pop_front()));
                end
            end
            if (pal_we_out) begin
                if (exp_pal_addr.size() == 0) unexpected("pal_we");
                else begin
                    check("pal_addr", 32'(pal_addr_out), 32'(exp_pal_addr.pop_front()));
                    check("pal_data", 32'(pal_data_out), 32'(exp_pal_data.pop_front()));
                end
            end
            if (load_done_out) begin
                if (exp_evt.size() == 0) unexpected("load_done");
                else check("evt_done", 32'(0), 32'(exp_evt.pop_front()));
            end
            if (load_error_out) begin
                if (exp_evt.size() == 0) unexpected("load_error");
                else check("evt_error", 32'(1), 32'(exp_evt.pop_front()));
            end
        end
    end

    initial begin
        rst_in        = 1'b1;
        byte_in       = 8'h00;
        byte_valid_in = 1'b0;
        idle(2);
        check("rst_busy",   32'(busy_out), 0);
        check("rst_img_we", 32'(img_we_out), 0);
        check("rst_pal_we", 32'(pal_we_out), 0);
        check("rst_done",   32'(load_done_out), 0);
        check("rst_error",  32'(load_error_out), 0);
        check("rst_img_addr", 32'(img_addr_out), 0);
        check("rst_pal_data", 32'(pal_data_out), 0);
        check("rst_ready",  32'(byte_ready_out), 0);
        rst_in = 1'b0;
        idle(1);
        check("ready", 32'(byte_ready_out), 1);

        // Image load of three entries at 0x10
        exp_img(10'h010, 8'h07); exp_img(10'h011, 8'h08); exp_img(10'h012, 8'h09);
        exp_evt.push_back(1'b0);
        frame_q = '{8'hA5, 8'h01, 8'h00, 8'h10, 8'h00, 8'h03, 8'h07, 8'h08, 8'h09};
        send_frame(0);
        check("img_done_latency", 32'(load_done_out), 1);
`ifndef SPRITE_LOADER_CHECKSUM_EN
        check("img_we_latency", 32'(img_we_out), 1);
`endif
        idle(2);

        // Palette load: two RGB entries at 5
        exp_pal(8'h05, 24'hFF0000); exp_pal(8'h06, 24'h00FF00);
        exp_evt.push_back(1'b0);
        frame_q = '{8'hA5, 8'h02, 8'h00, 8'h05, 8'h00, 8'h02,
                    8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00};
        send_frame(0);
        check("pal_done_latency", 32'(load_done_out), 1);
        idle(2);

        // Out of bounds: 0x2FF + 2 > 768
        exp_evt.push_back(1'b1);
        frame_q = '{8'hA5, 8'h01, 8'h02, 8'hFF, 8'h00, 8'h02};
        send_raw(0);
        check("bounds_err_pulse", 32'(load_error_out), 1);
        check("bounds_idle", 32'(busy_out), 0);
        idle(2);

        // Exactly at the boundary: 0x2FE + 2 == 768
        exp_img(10'h2FE, 8'hAA); exp_img(10'h2FF, 8'hBB);
        exp_evt.push_back(1'b0);
        frame_q = '{8'hA5, 8'h01, 8'h02, 8'hFE, 8'h00, 8'h02, 8'hAA, 8'hBB};
        send_frame(0);
        idle(2);

        // Garbage then bad command: one error, no writes
        exp_evt.push_back(1'b1);
        frame_q = '{8'h00, 8'h13, 8'hA5, 8'h03};
        send_raw(0);
        idle(2);

        // Palette frame ending at the last entry, with valid gaps throughout
        exp_pal(8'hFE, 24'h010203); exp_pal(8'hFF, 24'h0A0B0C);
        exp_evt.push_back(1'b0);
        frame_q = '{8'hA5, 8'h02, 8'h00, 8'hFE, 8'h00, 8'h02,
                    8'h01, 8'h02, 8'h03, 8'h0A, 8'h0B, 8'h0C};
        send_frame(2);
        idle(2);

        // Reset after second payload byte of a 4-entry frame
        exp_img(10'h020, 8'h11); exp_img(10'h021, 8'h22);
        frame_q = '{8'hA5, 8'h01, 8'h00, 8'h20, 8'h00, 8'h04, 8'h11, 8'h22};
        send_raw(0);
        check("midframe_busy", 32'(busy_out), 1);
        idle(1);
        rst_in = 1'b1;
        idle(2);
        check("abort_busy_in_rst", 32'(busy_out), 0);
        rst_in = 1'b0;
        idle(1);
        check("abort_busy_after", 32'(busy_out), 0);
        check("abort_ready", 32'(byte_ready_out), 1);
        // Leftover payload lands in idle and must be discarded
        frame_q = '{8'h33, 8'h44};
        send_raw(0);
        idle(2);

`ifdef SPRITE_LOADER_CHECKSUM_EN
        // Good checksum: XOR of 01 00 00 00 01 55 = 55
        exp_img(10'h000, 8'h55);
        exp_evt.push_back(1'b0);
        frame_q = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h55, 8'h55};
        send_raw(0);
        idle(2);
        // Bad checksum: write still happens, then error
        exp_img(10'h000, 8'h55);
        exp_evt.push_back(1'b1);
        frame_q = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h55, 8'h00};
        send_raw(0);
        check("csum_err_pulse", 32'(load_error_out), 1);
        idle(2);
`endif

        idle(5);
        check("img_left", 32'(exp_img_addr.size()), 0);
        check("pal_left", 32'(exp_pal_addr.size()), 0);
        check("evt_left", 32'(exp_evt.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
